// File: rtl/signed_round_cast_if.sv
// Stream bundle for signed_round_cast: input sample handshake, output sample
// handshake and the per-sample saturation flag travelling with dout.
interface signed_round_cast_if #(
   parameter int DIN_WIDTH  = 32,
   parameter int DOUT_WIDTH = 16
);
   logic signed [DIN_WIDTH-1:0]  din;
   logic                         din_valid;
   logic                         din_ready;
   logic signed [DOUT_WIDTH-1:0] dout;
   logic                         dout_valid;
   logic                         dout_ready;
   logic [1:0]                   warning;

   modport master (
      output din, din_valid, dout_ready,
      input  din_ready, dout, dout_valid, warning
   );

   modport slave (
      input  din, din_valid, dout_ready,
      output din_ready, dout, dout_valid, warning
   );
endinterface

// File: rtl/signed_round_cast.sv
// Two-stage fixed-point narrowing cast: S1 drops fractional LSBs with the
// selected rounding, S2 saturates to the output range and counts clipped samples.
module signed_round_cast #(
   parameter int DIN_WIDTH  = 32,
   parameter int DIN_POINT  = 16,
   parameter int DOUT_WIDTH = 16,
   parameter int DOUT_POINT = 8,
   parameter int ROUND_MODE = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   signed_round_cast_if.slave   bus,
   input  logic                 cnt_clear,
   output logic [CNT_WIDTH-1:0] ovf_count,
   output logic [CNT_WIDTH-1:0] unf_count
);

   localparam int D  = DIN_POINT - DOUT_POINT;
   localparam int RW = DIN_WIDTH + 1 - D;
   localparam int HS = (D > 0) ? D - 1 : 0;
   localparam logic [DIN_WIDTH:0] ONE  = (DIN_WIDTH+1)'(1);
   localparam logic [DIN_WIDTH:0] HALF = (D > 0) ? (ONE << HS) : '0;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [1:0] WARN_OK  = 2'd0;
   localparam logic [1:0] WARN_OVF = 2'd1;
   localparam logic [1:0] WARN_UNF = 2'd2;

   logic                  en;
   logic                  out_xfer;
   logic                  s1_valid;
   logic [RW-1:0]         s1_rnd;
   logic [DIN_WIDTH:0]    din_ext;
   logic [DIN_WIDTH:0]    rnd_c;
   logic [DIN_WIDTH:0]    rnd_sum;
   logic [RW-DOUT_WIDTH:0] sat_upper;
   logic [DOUT_WIDTH-1:0] sat_val;
   logic [1:0]            sat_warn;

   assign en            = ~bus.dout_valid | bus.dout_ready;
   assign bus.din_ready = en;
   assign out_xfer      = bus.dout_valid & bus.dout_ready;

   // One guard bit above the sign keeps din + C from wrapping at full scale.
   always_comb begin
      din_ext = {bus.din[DIN_WIDTH-1], bus.din};
      rnd_c   = '0;
      if (D > 0) begin
         case (ROUND_MODE)
            1:       rnd_c = HALF;
            2:       rnd_c = HALF - ONE + {{DIN_WIDTH{1'b0}}, bus.din[D]};
            default: rnd_c = '0;
         endcase
      end
      rnd_sum = din_ext + rnd_c;
   end

   // In range exactly when every bit from the output sign upward agrees.
   always_comb begin
      sat_upper = s1_rnd[RW-1:DOUT_WIDTH-1];
      sat_val   = s1_rnd[DOUT_WIDTH-1:0];
      sat_warn  = WARN_OK;
      if (!((&sat_upper) | ~(|sat_upper))) begin
         if (!s1_rnd[RW-1]) begin
            sat_val  = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
            sat_warn = WARN_OVF;
         end else begin
            sat_val  = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
            sat_warn = WARN_UNF;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid       <= 1'b0;
         s1_rnd         <= '0;
         bus.dout       <= '0;
         bus.dout_valid <= 1'b0;
         bus.warning    <= WARN_OK;
      end else if (en) begin
         s1_valid       <= bus.din_valid;
         bus.dout_valid <= s1_valid;
         if (bus.din_valid) begin
            s1_rnd <= rnd_sum[DIN_WIDTH:D];
         end
         if (s1_valid) begin
            bus.dout    <= sat_val;
            bus.warning <= sat_warn;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_count <= '0;
         unf_count <= '0;
      end else if (cnt_clear) begin
         ovf_count <= (out_xfer && bus.warning == WARN_OVF) ? CNT_ONE : '0;
         unf_count <= (out_xfer && bus.warning == WARN_UNF) ? CNT_ONE : '0;
      end else if (out_xfer) begin
         if (bus.warning == WARN_OVF && ovf_count != CNT_MAX) begin
            ovf_count <= ovf_count + CNT_ONE;
         end
         if (bus.warning == WARN_UNF && unf_count != CNT_MAX) begin
            unf_count <= unf_count + CNT_ONE;
         end
      end
   end

endmodule
